alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised, handshaked successor to the combinational RV32I ALU in the execute stage.
- Adds a registered output and valid/ready flow control on both sides.
- Adds an iterative restoring divider for the RV32M divide/remainder ops.
- Sits between decode/issue and writeback in stage 3.
- Single-cycle ops complete in 1 cycle; divides stall the issue side until they complete.

Parameters:
- XLEN, 32: operand/result width; must be a power of two, >= 8.
- SHAMT_W, $clog2(XLEN): shift-amount bits taken from src2 (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  4  operation code (alu_pkg::alu_op_e).
- src1  in  XLEN  operand A / dividend.
- src2  in  XLEN  operand B / divisor / shift amount.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- d_out  out  XLEN  result.
- illegal  out  1  qualifies d_out: op code not implemented.

Behaviour:
- Reset values: out_valid=0, d_out=0, illegal=0, FSM=IDLE, divider registers=0. in_ready is combinational and equals 1 after reset.
- Transfers occur on a rising edge when valid&&ready on the respective side.
- Op codes:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
  - 5 SLL, 6 SRL, 7 SRA: amount = src2[SHAMT_W-1:0].
  - 8 SLT (signed), 9 SLTU: result zero-extended 0/1.
  - 10 DIV, 11 DIVU, 12 REM, 13 REMU.
  - 14 MUL, 15 MULHU: optional, see below.
  - Arithmetic wraps modulo 2^XLEN; no flags.
- Output register: holds its value while out_valid && !out_ready. When empty or draining this cycle it may be refilled in the same cycle, so back-to-back throughput is 1 op/cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- FSM states:
  - IDLE
    - Accepted single-cycle op: result loaded into d_out next edge, out_valid=1. Latency 1.
    - Accepted div/rem with a special case: result loaded directly, latency 1.
      - Divisor==0: DIV/DIVU quotient = all ones; REM/REMU result = src1.
      - Signed overflow (src1 = 100..0, src2 = all ones): DIV result = src1; REM result = 0.
    - Accepted div/rem otherwise: operands latched as magnitudes, sign of quotient and remainder recorded, -> BUSY with count=XLEN-1.
    - Accepted unimplemented op: d_out=0, illegal=1, latency 1.
  - BUSY
    - One restoring quotient bit per cycle; count decrements.
    - At count==0 -> DONE.
    - in_ready=0 throughout BUSY.
  - DONE
    - Apply sign correction (quotient negated if signs differed; remainder takes dividend's sign).
    - Load d_out when !out_valid || out_ready, then -> IDLE.
    - If output is still occupied, stay in DONE.
- Total divide latency from accept to out_valid: XLEN+1 cycles minimum.
- Reset assertion mid-divide aborts it: state IDLE, out_valid=0; no partial result is ever emitted.
- illegal is updated with every d_out load and is 0 for implemented ops.

Optional Feature:
- Macro ALU_MC_MUL_EN.
- Defined:
  - Op 14 MUL returns the low XLEN bits of src1*src2.
  - Op 15 MULHU returns the high XLEN bits, unsigned.
  - Single-cycle combinational multiplier, latency 1.
- Undefined:
  - Ops 14/15 are unimplemented: d_out=0, illegal=1, latency 1.
  - No multiplier logic is synthesised.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the codes above.
  - typedef enum logic [1:0] alu_mc_state_e {IDLE, BUSY, DONE}.
  - Function is_div(alu_op_e).
- Sub-module div_iter holds the unsigned restoring divider datapath:
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - Owns the shift/subtract registers and bit counter.
- alu_mc owns the FSM, sign handling, special cases and output register.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001, out_ready=1: d_out=0x00000000, out_valid exactly 1 cycle after accept. SRA 0x80000000 by 0x24 (shamt 4): 0xF8000000.
- 10 back-to-back ops (SUB 5-7, then SLT -1<5, then SLTU -1<5, ...) with out_ready=1: in_ready stays 1, one result per cycle. Results: 0xFFFFFFFE, 1, 0.
- DIV -7/2: quotient 0xFFFFFFFD after 33 cycles. REM -7/2: 0xFFFFFFFF. in_ready=0 during BUSY.
- Special cases:
  - DIVU 5/0: 0xFFFFFFFF, latency 1.
  - REM 5/0: 5.
  - DIV 0x80000000 / 0xFFFFFFFF: 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF: 0.
- Backpressure: hold out_ready=0 for 4 cycles after an ADD result. d_out and out_valid are stable, in_ready=0. When out_ready rises, the next op is accepted in the same cycle.
- Assert rst_n low at BUSY cycle 10 of DIVU 100/3, then release: out_valid stays 0, next op is accepted normally. Op 14 with macro defined: 3*5 gives 15, illegal=0. Op 14 without macro: d_out=0, illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification for the multi-cycle ALU.
// Pure declarations; no timing or flow-control behaviour of its own.
// Codes 14/15 are multiplies, present only when ALU_MC_MUL_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_DIV   = 4'd10,
    ALU_DIVU  = 4'd11,
    ALU_REM   = 4'd12,
    ALU_REMU  = 4'd13,
    ALU_MUL   = 4'd14,
    ALU_MULHU = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_mc_state_e;

  function automatic logic is_div(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: XLEN cycles after start; done is high during the last step.
// No backpressure: the owner must hold results until it has consumed them.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dsor;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    trial;

  // The quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign shifted = {remainder, quotient[XLEN-1]};
  assign trial   = shifted - {1'b0, dsor};
  assign done    = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt       <= '0;
      dsor      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= CNT_W'(XLEN - 1);
      dsor      <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      if (!trial[XLEN]) begin
        remainder <= trial[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= shifted[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked RV32I/M execute ALU with registered result; multiplies gated by ALU_MC_MUL_EN.
// Latency: 1 cycle for single-cycle ops and divide special cases, XLEN+1 for iterative divides.
// Backpressure: result register holds while out_valid && !out_ready; issue stalls while dividing.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] d_out,
  output logic            illegal
);

  alu_op_e         op;
  alu_mc_state_e   state;
  logic            out_free;
  logic            accept;
  logic [SHAMT_W-1:0] shamt;

  logic            signed_div;
  logic            want_rem;
  logic            src1_neg;
  logic            src2_neg;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;

  logic [XLEN-1:0] comb_res;
  logic            comb_ill;
  logic            go_busy;

  logic            q_neg;
  logic            r_neg;
  logic            rem_sel;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            div_done;
  logic [XLEN-1:0] div_res;

  assign op       = alu_op_e'(alu_op);
  assign shamt    = src2[SHAMT_W-1:0];
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  assign signed_div = (op == ALU_DIV) || (op == ALU_REM);
  assign want_rem   = (op == ALU_REM) || (op == ALU_REMU);
  assign src1_neg   = signed_div && src1[XLEN-1];
  assign src2_neg   = signed_div && src2[XLEN-1];
  assign mag1       = src1_neg ? -src1 : src1;
  assign mag2       = src2_neg ? -src2 : src2;
  assign div0       = (src2 == '0);
  assign ovf        = signed_div && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);

`ifdef ALU_MC_MUL_EN
  logic [2*XLEN-1:0] prod;
  assign prod = {{XLEN{1'b0}}, src1} * {{XLEN{1'b0}}, src2};
`endif

  always_comb begin
    comb_res = '0;
    comb_ill = 1'b0;
    go_busy  = 1'b0;
    case (op)
      ALU_ADD:  comb_res = src1 + src2;
      ALU_SUB:  comb_res = src1 - src2;
      ALU_XOR:  comb_res = src1 ^ src2;
      ALU_OR:   comb_res = src1 | src2;
      ALU_AND:  comb_res = src1 & src2;
      ALU_SLL:  comb_res = src1 << shamt;
      ALU_SRL:  comb_res = src1 >> shamt;
      ALU_SRA:  comb_res = $signed(src1) >>> shamt;
      ALU_SLT:  comb_res = XLEN'($signed(src1) < $signed(src2));
      ALU_SLTU: comb_res = XLEN'(src1 < src2);
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        if (div0)     comb_res = want_rem ? src1 : '1;
        else if (ovf) comb_res = want_rem ? '0 : src1;
        else          go_busy  = 1'b1;
      end
`ifdef ALU_MC_MUL_EN
      ALU_MUL:   comb_res = prod[XLEN-1:0];
      ALU_MULHU: comb_res = prod[2*XLEN-1:XLEN];
`endif
      default:  comb_ill = 1'b1;
    endcase
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && go_busy),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  // Remainder follows the dividend's sign; quotient is negative when operand signs differ.
  assign div_res = rem_sel ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      d_out     <= '0;
      illegal   <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      rem_sel   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_busy) begin
              state   <= BUSY;
              q_neg   <= src1_neg ^ src2_neg;
              r_neg   <= src1_neg;
              rem_sel <= want_rem;
            end else begin
              d_out     <= comb_res;
              illegal   <= comb_ill;
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (div_done) state <= DONE;
        end
        DONE: begin
          if (out_free) begin
            d_out     <= div_res;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
